// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the SRAM bus arbiter
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } arb_owner_t;

  typedef struct packed {
    logic        wr;
    logic [2:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  localparam logic [2:0] SZ_WORD_CODE = 3'd2;

endpackage

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - fetch, data and bus port signals of the arbiter
interface sram_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [2:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        bus_req;
  logic        bus_wr;
  logic [2:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  // Arbiter side.
  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  // Pipeline and bus bridge side.
  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational winner select; SRAM_ARB_RR_EN selects round-robin
module arb_pick
  import arb_pkg::*;
(
  input  logic       inst_req_i,
  input  logic       data_req_i,
`ifdef SRAM_ARB_RR_EN
  input  arb_owner_t last_grant_i,
`endif
  output logic       valid_o,
  output arb_owner_t owner_o
);

  always_comb begin
    valid_o = inst_req_i | data_req_i;
    owner_o = OWNER_INST;
    if (inst_req_i && data_req_i) begin
`ifdef SRAM_ARB_RR_EN
      owner_o = (last_grant_i == OWNER_INST) ? OWNER_DATA : OWNER_INST;
`else
      owner_o = OWNER_DATA;
`endif
    end else if (data_req_i) begin
      owner_o = OWNER_DATA;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one SRAM-like bus between fetch and data ports; SRAM_ARB_RR_EN enables round-robin
module sram_arbiter
  import arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave io
);

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;
  mem_req_t   req_q, req_d;
  mem_req_t   inst_fields, data_fields;
  arb_owner_t pick_owner;
  logic       pick_valid;
  logic       data_done;
  logic       grant;

`ifdef SRAM_ARB_RR_EN
  arb_owner_t last_grant_q;

  arb_pick u_pick (
    .inst_req_i   (io.inst_req),
    .data_req_i   (io.data_req),
    .last_grant_i (last_grant_q),
    .valid_o      (pick_valid),
    .owner_o      (pick_owner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= OWNER_INST;
    end else if (grant) begin
      last_grant_q <= pick_owner;
    end
  end
`else
  arb_pick u_pick (
    .inst_req_i (io.inst_req),
    .data_req_i (io.data_req),
    .valid_o    (pick_valid),
    .owner_o    (pick_owner)
  );
`endif

  // A completing data phase frees the bus in the same cycle, so a new grant may overlap it.
  assign data_done = !rst && (state_q == ST_DATA) && io.bus_data_ok;
  assign grant     = !rst && pick_valid && ((state_q == ST_IDLE) || data_done);

  always_comb begin
    inst_fields = '{wr: 1'b0, size: SZ_WORD_CODE, wstrb: 4'h0,
                    addr: io.inst_addr, wdata: 32'h0};
    data_fields = '{wr: io.data_wr, size: io.data_size, wstrb: io.data_wstrb,
                    addr: io.data_addr, wdata: io.data_wdata};
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    req_d   = req_q;
    unique case (state_q)
      ST_IDLE: if (grant) state_d = ST_ADDR;
      ST_ADDR: if (io.bus_addr_ok) state_d = ST_DATA;
      ST_DATA: if (data_done) state_d = grant ? ST_ADDR : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (grant) begin
      owner_d = pick_owner;
      req_d   = (pick_owner == OWNER_DATA) ? data_fields : inst_fields;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWNER_INST;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      req_q   <= req_d;
    end
  end

  assign io.inst_addr_ok = grant && (pick_owner == OWNER_INST);
  assign io.data_addr_ok = grant && (pick_owner == OWNER_DATA);
  assign io.inst_data_ok = data_done && (owner_q == OWNER_INST);
  assign io.data_data_ok = data_done && (owner_q == OWNER_DATA);
  assign io.inst_rdata   = io.inst_data_ok ? io.bus_rdata : 32'h0;
  assign io.data_rdata   = io.data_data_ok ? io.bus_rdata : 32'h0;

  assign io.bus_req   = (state_q == ST_ADDR);
  assign io.bus_wr    = req_q.wr;
  assign io.bus_size  = req_q.size;
  assign io.bus_wstrb = req_q.wstrb;
  assign io.bus_addr  = req_q.addr;
  assign io.bus_wdata = req_q.wdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   tests_run = 0;
  int   failed = 0;

  sram_arbiter_if sif ();

  sram_arbiter dut (
    .clk (clk),
    .rst (rst),
    .io  (sif)
  );

  always #5 clk = ~clk;

  logic [140:0] all_out;
  assign all_out = {sif.inst_addr_ok, sif.inst_data_ok, sif.inst_rdata,
                    sif.data_addr_ok, sif.data_data_ok, sif.data_rdata,
                    sif.bus_req, sif.bus_wr, sif.bus_size, sif.bus_wstrb,
                    sif.bus_addr, sif.bus_wdata};

`ifdef SRAM_ARB_RR_EN
  localparam logic [3:0] TIE_SEQ = 4'b0101;
`else
  localparam logic [3:0] TIE_SEQ = 4'b1111;
`endif

  task automatic idle_inputs();
    sif.inst_req    = 1'b0;
    sif.inst_addr   = 32'h0;
    sif.data_req    = 1'b0;
    sif.data_wr     = 1'b0;
    sif.data_size   = 3'd0;
    sif.data_wstrb  = 4'h0;
    sif.data_addr   = 32'h0;
    sif.data_wdata  = 32'h0;
    sif.bus_addr_ok = 1'b0;
    sif.bus_data_ok = 1'b0;
    sif.bus_rdata   = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    tests_run++; if (all_out !== 141'h0) begin failed++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    tests_run++; if (sif.bus_req !== 1'b0) begin failed++; $display("FAIL reset_bus_req: got %b want 0", sif.bus_req); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    @(negedge clk);
    sif.inst_req = 1'b1; sif.inst_addr = 32'hBFC00000;
    #1;
    tests_run++; if (sif.inst_addr_ok !== 1'b1) begin failed++; $display("FAIL fetch_addr_ok: got %b want 1", sif.inst_addr_ok); end
    tests_run++; if ({sif.data_addr_ok, sif.bus_req} !== 2'b00) begin failed++; $display("FAIL fetch_c0_other: got %b want 00", {sif.data_addr_ok, sif.bus_req}); end
    @(negedge clk);
    sif.inst_req = 1'b0; sif.bus_addr_ok = 1'b1;
    #1;
    tests_run++; if ({sif.bus_req, sif.bus_addr} !== {1'b1, 32'hBFC00000}) begin failed++; $display("FAIL fetch_bus_addr: got %b %h want 1 bfc00000", sif.bus_req, sif.bus_addr); end
    tests_run++; if ({sif.bus_wr, sif.bus_size, sif.bus_wstrb, sif.bus_wdata} !== {1'b0, 3'd2, 4'h0, 32'h0}) begin failed++; $display("FAIL fetch_bus_fields: got %b %0d %h %h want 0 2 0 0", sif.bus_wr, sif.bus_size, sif.bus_wstrb, sif.bus_wdata); end
    tests_run++; if (sif.inst_addr_ok !== 1'b0) begin failed++; $display("FAIL fetch_c1_addr_ok: got %b want 0", sif.inst_addr_ok); end
    @(negedge clk);
    sif.bus_addr_ok = 1'b0; sif.bus_data_ok = 1'b1; sif.bus_rdata = 32'h3C1D8000;
    #1;
    tests_run++; if ({sif.inst_data_ok, sif.inst_rdata} !== {1'b1, 32'h3C1D8000}) begin failed++; $display("FAIL fetch_data: got %b %h want 1 3c1d8000", sif.inst_data_ok, sif.inst_rdata); end
    tests_run++; if ({sif.data_data_ok, sif.bus_req} !== 2'b00) begin failed++; $display("FAIL fetch_c2_other: got %b want 00", {sif.data_data_ok, sif.bus_req}); end
    @(negedge clk);
    sif.bus_data_ok = 1'b0;
    #1;
    tests_run++; if ({sif.inst_data_ok, sif.data_data_ok, sif.bus_req} !== 3'b000) begin failed++; $display("FAIL fetch_c3_idle: got %b want 000", {sif.inst_data_ok, sif.data_data_ok, sif.bus_req}); end
  endtask

  task automatic test_tie();
    do_reset();
    @(negedge clk);
    sif.inst_req = 1'b1; sif.inst_addr = 32'h00000100;
    sif.data_req = 1'b1; sif.data_size = 3'd2; sif.data_addr = 32'h00002000;
    #1;
    tests_run++; if ({sif.data_addr_ok, sif.inst_addr_ok} !== 2'b10) begin failed++; $display("FAIL tie_first_grant: got d=%b i=%b want d=1 i=0", sif.data_addr_ok, sif.inst_addr_ok); end
    @(negedge clk);
    sif.data_req = 1'b0; sif.bus_addr_ok = 1'b1;
    #1;
    tests_run++; if ({sif.inst_addr_ok, sif.bus_addr} !== {1'b0, 32'h00002000}) begin failed++; $display("FAIL tie_c1: got i_ok=%b addr=%h want 0 00002000", sif.inst_addr_ok, sif.bus_addr); end
    @(negedge clk);
    sif.bus_addr_ok = 1'b0; sif.bus_data_ok = 1'b1; sif.bus_rdata = 32'h11112222;
    #1;
    tests_run++; if ({sif.data_data_ok, sif.data_rdata, sif.inst_data_ok} !== {1'b1, 32'h11112222, 1'b0}) begin failed++; $display("FAIL tie_data_done: got %b %h %b want 1 11112222 0", sif.data_data_ok, sif.data_rdata, sif.inst_data_ok); end
    tests_run++; if ({sif.inst_addr_ok, sif.data_addr_ok} !== 2'b10) begin failed++; $display("FAIL tie_second_grant: got i=%b d=%b want i=1 d=0", sif.inst_addr_ok, sif.data_addr_ok); end
    @(negedge clk);
    sif.inst_req = 1'b0; sif.bus_data_ok = 1'b0; sif.bus_addr_ok = 1'b1;
    #1;
    tests_run++; if ({sif.bus_req, sif.bus_addr} !== {1'b1, 32'h00000100}) begin failed++; $display("FAIL tie_c3_bus: got %b %h want 1 00000100", sif.bus_req, sif.bus_addr); end
    @(negedge clk);
    sif.bus_addr_ok = 1'b0; sif.bus_data_ok = 1'b1; sif.bus_rdata = 32'h33334444;
    #1;
    tests_run++; if ({sif.inst_data_ok, sif.inst_rdata, sif.data_data_ok} !== {1'b1, 32'h33334444, 1'b0}) begin failed++; $display("FAIL tie_inst_done: got %b %h %b want 1 33334444 0", sif.inst_data_ok, sif.inst_rdata, sif.data_data_ok); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_sustained_tie();
    logic exp_d;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_d = TIE_SEQ[i];
      @(negedge clk);
      sif.inst_req = 1'b1; sif.inst_addr = 32'h00000100;
      sif.data_req = 1'b1; sif.data_size = 3'd2; sif.data_addr = 32'h00002000;
      sif.bus_addr_ok = 1'b0; sif.bus_data_ok = (i != 0);
      #1;
      tests_run++; if ({sif.data_addr_ok, sif.inst_addr_ok} !== {exp_d, !exp_d}) begin failed++; $display("FAIL sustained_grant%0d: got d=%b i=%b want d=%b", i, sif.data_addr_ok, sif.inst_addr_ok, exp_d); end
      @(negedge clk);
      sif.bus_data_ok = 1'b0; sif.bus_addr_ok = 1'b1;
      #1;
      tests_run++; if (sif.bus_addr !== (exp_d ? 32'h00002000 : 32'h00000100)) begin failed++; $display("FAIL sustained_addr%0d: got %h", i, sif.bus_addr); end
    end
    @(negedge clk);
    idle_inputs(); sif.bus_data_ok = 1'b1;
    @(negedge clk);
    sif.bus_data_ok = 1'b0;
  endtask

  task automatic test_store();
    do_reset();
    @(negedge clk);
    sif.data_req = 1'b1; sif.data_wr = 1'b1; sif.data_size = 3'd1; sif.data_wstrb = 4'b1100;
    sif.data_addr = 32'h80001002; sif.data_wdata = 32'hBEEFBEEF;
    #1;
    tests_run++; if (sif.data_addr_ok !== 1'b1) begin failed++; $display("FAIL store_addr_ok: got %b want 1", sif.data_addr_ok); end
    @(negedge clk);
    sif.data_req = 1'b0; sif.bus_addr_ok = 1'b1;
    #1;
    tests_run++; if ({sif.bus_req, sif.bus_wr, sif.bus_size, sif.bus_wstrb, sif.bus_addr, sif.bus_wdata} !== {1'b1, 1'b1, 3'd1, 4'b1100, 32'h80001002, 32'hBEEFBEEF}) begin failed++; $display("FAIL store_bus_fields: got req=%b wr=%b sz=%0d strb=%h addr=%h wd=%h", sif.bus_req, sif.bus_wr, sif.bus_size, sif.bus_wstrb, sif.bus_addr, sif.bus_wdata); end
    @(negedge clk);
    sif.bus_addr_ok = 1'b0; sif.bus_data_ok = 1'b1;
    #1;
    tests_run++; if ({sif.data_data_ok, sif.inst_data_ok} !== 2'b10) begin failed++; $display("FAIL store_done: got d=%b i=%b want d=1 i=0", sif.data_data_ok, sif.inst_data_ok); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_wait_states();
    do_reset();
    @(negedge clk);
    sif.inst_req = 1'b1; sif.inst_addr = 32'h00001000;
    #1;
    tests_run++; if (sif.inst_addr_ok !== 1'b1) begin failed++; $display("FAIL wait_accept: got %b want 1", sif.inst_addr_ok); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sif.inst_req = 1'b0;
      sif.data_req = 1'b1; sif.data_size = 3'd2; sif.data_addr = 32'h00003000;
      sif.bus_addr_ok = (i == 3); sif.bus_data_ok = (i == 1);
      #1;
      tests_run++; if ({sif.bus_req, sif.bus_addr, sif.bus_size} !== {1'b1, 32'h00001000, 3'd2}) begin failed++; $display("FAIL wait_addr_hold%0d: got %b %h %0d", i, sif.bus_req, sif.bus_addr, sif.bus_size); end
      tests_run++; if ({sif.inst_addr_ok, sif.data_addr_ok, sif.inst_data_ok} !== 3'b000) begin failed++; $display("FAIL wait_addr_busy%0d: got %b want 000", i, {sif.inst_addr_ok, sif.data_addr_ok, sif.inst_data_ok}); end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sif.bus_addr_ok = 1'b0; sif.bus_data_ok = 1'b0;
      #1;
      tests_run++; if ({sif.bus_req, sif.inst_addr_ok, sif.data_addr_ok, sif.inst_data_ok, sif.data_data_ok} !== 5'b0) begin failed++; $display("FAIL wait_data_busy%0d: got %b want 00000", i, {sif.bus_req, sif.inst_addr_ok, sif.data_addr_ok, sif.inst_data_ok, sif.data_data_ok}); end
    end
    @(negedge clk);
    sif.bus_data_ok = 1'b1; sif.bus_rdata = 32'hCAFEF00D;
    #1;
    tests_run++; if ({sif.inst_data_ok, sif.inst_rdata, sif.data_addr_ok} !== {1'b1, 32'hCAFEF00D, 1'b1}) begin failed++; $display("FAIL wait_done_regrant: got %b %h %b want 1 cafef00d 1", sif.inst_data_ok, sif.inst_rdata, sif.data_addr_ok); end
    @(negedge clk);
    sif.data_req = 1'b0; sif.bus_data_ok = 1'b0; sif.bus_addr_ok = 1'b1;
    #1;
    tests_run++; if ({sif.bus_req, sif.bus_addr} !== {1'b1, 32'h00003000}) begin failed++; $display("FAIL wait_next_bus: got %b %h want 1 00003000", sif.bus_req, sif.bus_addr); end
    @(negedge clk);
    sif.bus_addr_ok = 1'b0; sif.bus_data_ok = 1'b1;
    #1;
    tests_run++; if ({sif.data_data_ok, sif.inst_data_ok} !== 2'b10) begin failed++; $display("FAIL wait_next_done: got d=%b i=%b want d=1 i=0", sif.data_data_ok, sif.inst_data_ok); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_in_data();
    do_reset();
    @(negedge clk);
    sif.inst_req = 1'b1; sif.inst_addr = 32'h00004000;
    #1;
    tests_run++; if (sif.inst_addr_ok !== 1'b1) begin failed++; $display("FAIL rstdata_accept: got %b want 1", sif.inst_addr_ok); end
    @(negedge clk);
    sif.inst_req = 1'b0; sif.bus_addr_ok = 1'b1;
    @(negedge clk);
    sif.bus_addr_ok = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; sif.bus_data_ok = 1'b1; sif.bus_rdata = 32'hDEADBEEF;
    #1;
    tests_run++; if (all_out !== 141'h0) begin failed++; $display("FAIL rstdata_stale_drop: got %h want 0", all_out); end
    @(negedge clk);
    sif.bus_data_ok = 1'b0; sif.inst_req = 1'b1; sif.inst_addr = 32'h00005000;
    #1;
    tests_run++; if (sif.inst_addr_ok !== 1'b1) begin failed++; $display("FAIL rstdata_reaccept: got %b want 1", sif.inst_addr_ok); end
    @(negedge clk);
    sif.inst_req = 1'b0; sif.bus_addr_ok = 1'b1;
    #1;
    tests_run++; if ({sif.bus_req, sif.bus_addr} !== {1'b1, 32'h00005000}) begin failed++; $display("FAIL rstdata_bus: got %b %h want 1 00005000", sif.bus_req, sif.bus_addr); end
    @(negedge clk);
    sif.bus_addr_ok = 1'b0; sif.bus_data_ok = 1'b1; sif.bus_rdata = 32'h12345678;
    #1;
    tests_run++; if ({sif.inst_data_ok, sif.inst_rdata} !== {1'b1, 32'h12345678}) begin failed++; $display("FAIL rstdata_done: got %b %h want 1 12345678", sif.inst_data_ok, sif.inst_rdata); end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_tie();
    test_sustained_tie();
    test_store();
    test_wait_states();
    test_reset_in_data();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single SRAM-like memory bus between the instruction-fetch port and the data port fed by the load/store unit. Grants one requester at a time and latches its request. Drives the bus address phase, then routes the read data and data-phase handshake back to the owner. Sits between the core pipeline (fetch stage, memory stage) and the cache/bus bridge, with one transaction outstanding at a time.

## Interface
- No parameters. Address and data widths are fixed at 32 bits.
- `clk`  in  1  core clock; all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `inst_req`  in  1  fetch request; held stable until `inst_addr_ok`
- `inst_addr`  in  32  fetch address (always a word read)
- `inst_addr_ok`  out  1  fetch request accepted this cycle
- `inst_data_ok`  out  1  fetch data valid this cycle
- `inst_rdata`  out  32  fetch data
- `data_req`  in  1  data request (driven from `mem_en`); held until `data_addr_ok`
- `data_wr`  in  1  1 = store
- `data_size`  in  3  0 = byte, 1 = half, 2 = word
- `data_wstrb`  in  4  byte enables (stores only)
- `data_addr`  in  32  data address
- `data_wdata`  in  32  store data
- `data_addr_ok`  out  1  data request accepted this cycle
- `data_data_ok`  out  1  load data / store completion valid
- `data_rdata`  out  32  load data
- `bus_req`  out  1  address-phase request
- `bus_wr`, `bus_size`[3], `bus_wstrb`[4], `bus_addr`[32], `bus_wdata`[32]  out  latched request fields
- `bus_addr_ok`  in  1  bus accepted the address phase
- `bus_data_ok`  in  1  bus completed the data phase
- `bus_rdata`  in  32  bus read data

## Operation
- **FSM** has three states: IDLE, ADDR, DATA.
- **IDLE.** If any request is present, pick a winner, latch its fields, pulse its `*_addr_ok`, and go to ADDR. Otherwise stay in IDLE.
- **ADDR.** Hold `bus_req = 1` with the latched fields. On `bus_addr_ok`, go to DATA. `bus_data_ok` is ignored in this state.
- **DATA.** Hold `bus_req = 0`.
  - On `bus_data_ok`: assert the owner's `*_data_ok` combinationally and pass `bus_rdata` to the owner's `*_rdata`.
  - In that same cycle, if a request is pending, perform a new grant exactly as in IDLE (accept it, latch it) and go to ADDR. Otherwise go to IDLE.
- **Instruction transactions** are driven as `bus_wr = 0`, `bus_size = 2`, `bus_wstrb = 0`, `bus_wdata = 0`.
- **Data transactions** copy `data_wr`, `data_size`, `data_wstrb` and `data_wdata` unchanged. For a store, `data_data_ok` marks write completion and `data_rdata` is don't-care.
- **Fixed-priority arbitration** (default): data beats instruction, so memory-stage stalls clear first.
- **No cancellation.** An accepted transaction always runs to `bus_data_ok`. The non-owner's `*_data_ok` is never asserted.

## Timing
- **Reset values:** state = IDLE; all outputs 0, including the latched bus fields and the owner register.
- **Minimum latency** (zero-wait bus):
  - cycle 0: accept (`*_addr_ok`)
  - cycle 1: `bus_req` and `bus_addr_ok`
  - cycle 2: `bus_data_ok`, owner's `*_data_ok`, and the next accept
- **Throughput:** one transaction per 2 cycles sustained.
- **`*_addr_ok`** is a single-cycle pulse, and only while the matching `*_req` is high.
- **Simultaneous `inst_req` and `data_req`:** exactly one `*_addr_ok` is asserted per cycle. The loser holds its request.
- **`rst` mid-transaction:** next cycle is IDLE with `bus_req = 0`. Any stale `bus_data_ok` that arrives in IDLE is dropped. The bus bridge is reset by the same `rst`.
- **`bus_data_ok` in IDLE or ADDR** is ignored.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin arbitration.
  - A `last_grant` register is set to the owner at each grant.
  - When both ports request, the port not equal to `last_grant` wins.
  - `last_grant` resets to instruction, so data wins the first tie.
- `SRAM_ARB_RR_EN` undefined: fixed data priority. The `last_grant` register is absent.

## Structure
- **Shared package** `arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE/ADDR/DATA);
  - the owner enum `arb_owner_t` (INST/DATA);
  - a packed struct `mem_req_t` {wr, size, wstrb, addr, wdata};
  - the constant `SZ_WORD_CODE = 3'd2`.
- **One sub-module** `arb_pick`: a combinational winner select over {inst_req, data_req, last_grant}. It implements both arbitration modes under the macro.

## Test plan
- **Single fetch:** `inst_req` with addr 0xBFC00000; zero-wait bus returns 0x3C1D8000.
  - Expect `inst_addr_ok` at cycle 0, `bus_req` at cycle 1, `inst_data_ok` with rdata 0x3C1D8000 at cycle 2.
  - `data_data_ok` never asserts.
- **Tie:** `inst_req` and `data_req` both high at cycle 0.
  - Fixed mode: data granted first, inst granted at cycle 2.
  - RR mode with sustained ties: grants alternate D, I, D, I.
- **Store:** addr 0x80001002, size 1, wstrb 0b1100, wdata 0xBEEFBEEF.
  - Bus sees `bus_wr = 1` with identical fields.
  - `data_data_ok` arrives on `bus_data_ok`.
- **Wait states:** `bus_addr_ok` delayed 3 cycles, `bus_data_ok` delayed 4 cycles.
  - `bus_req` and fields stay stable for 4 cycles.
  - No `*_addr_ok` while busy.
- **Reset in DATA:** assert `rst` one cycle, then inject `bus_data_ok`.
  - Expect no `*_data_ok` and all outputs 0.
  - Next request is accepted normally.
